axis_lane_adder: RTL and testbench
==================================

Name: axis_lane_adder

Overview:
- Next-generation AXI-Stream packet adder: adds a per-packet configured constant to every DW-bit lane of every beat.
- Generalised to LANES parallel lanes per beat, with selectable wrap, saturate, subtract and bypass modes.
- Config is latched at packet start; a registered skid buffer gives a fully registered s_tready.
- Sits between the ingress FIFO and the egress stream, replacing the dual-FIFO sum structure.

Parameters:
- DW, 8, lane width in bits (>=2)
- LANES, 4, lanes per beat; tdata width is LANES*DW
- CNTW, 16, width of the packet counter and overflow counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- s_tdata  in  LANES*DW  input beat; lane i is bits [i*DW +: DW]
- s_tvalid  in  1  input valid
- s_tlast  in  1  input last beat of packet
- s_tready  out  1  input ready (registered)
- cfg_addend  in  DW  unsigned constant applied to each lane
- cfg_mode  in  2  00 wrap add, 01 saturate add, 10 saturate subtract (floor 0), 11 bypass
- m_tdata  out  LANES*DW  result beat
- m_tvalid  out  1  output valid
- m_tlast  out  1  output last
- m_tuser  out  1  on the tlast beat only: 1 if any lane of the packet overflowed, clipped or wrapped
- m_tready  in  1  output ready
- pkt_count  out  CNTW  packets completed on the output side, wraps at 2^CNTW
- ovf_count  out  CNTW  packets emitted with m_tuser=1, saturates at all-ones

Behaviour:
- Reset (rst=0, asynchronous) drives: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, pkt_count=0, ovf_count=0, FSM=IDLE, skid buffer empty, latched cfg=0, sticky flag=0.
- The cycle after reset deasserts, s_tready=1.
- Reset mid-packet discards all buffered beats and the partial packet; no output is produced for it.
- Handshakes:
  - A beat transfers when valid&&ready.
  - m_tvalid, m_tdata, m_tlast and m_tuser are held stable while m_tvalid&&!m_tready.
  - s_tvalid may not depend on s_tready.
- Latency and throughput:
  - The main output register has 1-cycle latency: a beat accepted in cycle N is visible in cycle N+1.
  - Throughput is 1 beat/cycle while m_tready=1.
- Skid buffer (2 entries: main + skid):
  - s_tready is a registered signal equal to "skid entry empty".
  - If m_tready drops while the main entry is valid and a beat is accepted the same cycle, that beat goes to the skid entry and s_tready falls next cycle.
  - When the main entry drains, the skid entry moves to main and s_tready rises next cycle.
  - No beat is lost or duplicated under any m_tready pattern.
- Packet FSM, which tracks the input side:
  - IDLE: on an accepted beat, latch cfg_addend and cfg_mode. That first beat uses the live cfg inputs. Go to BODY unless s_tlast=1; a 1-beat packet stays in IDLE.
  - BODY: accepted beats use the latched cfg; cfg input changes are ignored. An accepted beat with s_tlast=1 returns to IDLE.
- Arithmetic, per lane, DW+1-bit intermediate:
  - Wrap: sum mod 2^DW; event if carry=1.
  - Saturate add: result min(sum, 2^DW-1); event if clipped.
  - Saturate subtract: result max(lane-addend, 0); event if borrow.
  - Bypass: lane unchanged; never an event.
- Sticky overflow flag:
  - Set by any lane event on an accepted beat.
  - m_tuser on the tlast beat = sticky flag OR events of that beat.
  - The flag clears on acceptance of the tlast beat; m_tuser=0 on non-last beats.
- Counters:
  - pkt_count increments on the output handshake of a beat with m_tlast=1.
  - ovf_count increments on the same handshake when m_tuser=1; it holds at all-ones.

Decomposition:
- Package axis_lane_adder_pkg holds:
  - typedef mode_e {MODE_WRAP, MODE_SAT_ADD, MODE_SAT_SUB, MODE_BYPASS}
  - typedef state_e {ST_IDLE, ST_BODY}
  - a function lane_op(lane, addend, mode) returning {event, result}
- Sub-module axis_skid_buffer (parameter width = LANES*DW+2) holds the 2-entry registered-ready slice.
- The adder generates LANES instances of lane_op in front of the skid buffer.

Test Plan:
- Wrap mode, DW=8, LANES=4: addend 0x10, 1-beat packet 0xFFF0_2001 -> m_tdata 0x0F00_3011, m_tuser=1, pkt_count=1.
- Saturate add: addend 0x20, lanes {0xF0,0x01,0xE0,0x7F} -> {0xFF,0x21,0xFF,0x9F}, m_tuser=1 on last beat, ovf_count=1.
- Config latching: 3-beat packet started with addend 5, cfg_addend changed to 9 at beat 2 -> all beats +5; next packet uses 9.
- Backpressure: m_tready low for 3 cycles during a 6-beat stream -> s_tready falls exactly 1 cycle after skid fills; all 6 beats emitted in order, unchanged.
- Saturate subtract with no borrow across a 4-beat packet, addend 1 on lanes >=1 -> m_tuser=0, ovf_count unchanged. Bypass mode -> m_tdata equals s_tdata.
- Async reset asserted mid-packet with beats in both entries -> m_tvalid=0 immediately, counters 0; the next packet is processed using its own first-beat cfg.

Source files
------------

// File: rtl/axis_lane_adder_pkg.sv
// axis_lane_adder_pkg: shared types and the per-lane arithmetic for the lane adder
package axis_lane_adder_pkg;
   localparam int MAXW = 32;
   typedef enum logic [1:0] {MODE_WRAP, MODE_SAT_ADD, MODE_SAT_SUB, MODE_BYPASS} mode_e;
   typedef enum logic {ST_IDLE, ST_BODY} state_e;
   typedef struct packed {
      logic            evt;
      logic [MAXW-1:0] res;
   } lane_res_t;
   // One lane of width dw (zero-extended to MAXW); evt flags carry, clip or borrow
   function automatic lane_res_t lane_op(input logic [MAXW-1:0] lane, input logic [MAXW-1:0] addend,
                                         input mode_e mode, input int dw);
      logic [MAXW:0] sum, lim;
      lane_res_t r;
      sum = {1'b0, lane} + {1'b0, addend};
      lim = {1'b0, {MAXW{1'b1}}} >> (MAXW - dw);
      r.evt = 1'b0;
      r.res = lane;
      case (mode)
         MODE_WRAP: begin
            r.evt = sum > lim;
            r.res = MAXW'(sum & lim);
         end
         MODE_SAT_ADD: begin
            r.evt = sum > lim;
            r.res = r.evt ? MAXW'(lim) : MAXW'(sum);
         end
         MODE_SAT_SUB: begin
            r.evt = addend > lane;
            r.res = r.evt ? '0 : lane - addend;
         end
         default: ;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/axis_lane_adder_if.sv
// axis_lane_adder_if: AXI-Stream beat bundle used for both adder ports
interface axis_lane_adder_if #(parameter int W = 32);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tlast;
   logic         tuser;
   logic         tready;
   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry register slice whose input ready is a flop ("skid empty")
module axis_skid_buffer #(parameter int W = 34) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] data_i,
   input  logic         valid_i,
   output logic         ready_o,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   input  logic         ready_i
);
   logic [W-1:0] main_q, main_d, skid_q, skid_d;
   logic main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, acc, free;
   assign ready_o = rdy_q;
   assign data_o  = main_q;
   assign valid_o = main_v_q;
   // Main refills from skid first, then input; skid only catches a beat the stalled main cannot take
   always_comb begin
      acc      = valid_i && rdy_q;
      free     = !main_v_q || ready_i;
      main_d   = free ? (skid_v_q ? skid_q : acc ? data_i : main_q) : main_q;
      main_v_d = free ? skid_v_q || acc : main_v_q;
      skid_d   = !free && acc ? data_i : skid_q;
      skid_v_d = free ? 1'b0 : skid_v_q || acc;
   end
   // Entry registers; ready follows the next-state skid occupancy
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         rdy_q    <= !skid_v_d;
      end
endmodule

// File: rtl/axis_lane_adder.sv
// axis_lane_adder: adds a per-packet latched constant to every lane of every AXI-Stream beat
module axis_lane_adder
   import axis_lane_adder_pkg::*;
#(
   parameter int DW    = 8,
   parameter int LANES = 4,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   axis_lane_adder_if.slave  s,
   axis_lane_adder_if.master m,
   input  logic [DW-1:0]    cfg_addend,
   input  logic [1:0]       cfg_mode,
   output logic [CNTW-1:0]  pkt_count,
   output logic [CNTW-1:0]  ovf_count
);
   localparam int W = LANES * DW;
   state_e state_q, state_d;
   mode_e mode_q, mode_d, eff_mode;
   logic [DW-1:0] add_q, add_d, eff_add;
   logic sticky_q, sticky_d, acc, beat_user, m_last_hs, tuser_unused;
   logic [W-1:0] res;
   logic [LANES-1:0] evt, hi_unused;
   logic [W+1:0] out_data;
   logic [CNTW-1:0] pkt_q, ovf_q;
   assign eff_add      = state_q == ST_IDLE ? cfg_addend : add_q;
   assign eff_mode     = state_q == ST_IDLE ? mode_e'(cfg_mode) : mode_q;
   assign tuser_unused = s.tuser;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_res_t r;
      assign r                 = lane_op(MAXW'(s.tdata[i*DW +: DW]), MAXW'(eff_add), eff_mode, DW);
      assign res[i*DW +: DW]   = r.res[DW-1:0];
      assign evt[i]            = r.evt;
      assign hi_unused[i]      = ^r.res;
   end
   // Packet FSM, config latch on the first beat and the sticky per-packet event flag
   always_comb begin
      acc       = s.tvalid && s.tready;
      state_d   = acc ? (s.tlast ? ST_IDLE : ST_BODY) : state_q;
      add_d     = acc && state_q == ST_IDLE ? cfg_addend : add_q;
      mode_d    = acc && state_q == ST_IDLE ? mode_e'(cfg_mode) : mode_q;
      beat_user = s.tlast && (sticky_q || |evt);
      sticky_d  = acc ? !s.tlast && (sticky_q || |evt) : sticky_q;
   end
   // Input-side packet state
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q  <= ST_IDLE;
         add_q    <= '0;
         mode_q   <= MODE_WRAP;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         add_q    <= add_d;
         mode_q   <= mode_d;
         sticky_q <= sticky_d;
      end
   axis_skid_buffer #(.W(W + 2)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .data_i  ({beat_user, s.tlast, res}),
      .valid_i (s.tvalid),
      .ready_o (s.tready),
      .data_o  (out_data),
      .valid_o (m.tvalid),
      .ready_i (m.tready)
   );
   assign {m.tuser, m.tlast, m.tdata} = out_data;
   assign m_last_hs = m.tvalid && m.tready && m.tlast;
   assign pkt_count = pkt_q;
   assign ovf_count = ovf_q;
   // Output-side packet counters; the overflow counter sticks at all-ones
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pkt_q <= '0;
         ovf_q <= '0;
      end else if (m_last_hs) begin
         pkt_q <= pkt_q + 1'b1;
         if (m.tuser && !(&ovf_q)) ovf_q <= ovf_q + 1'b1;
      end
endmodule

// File: tb/tb_axis_lane_adder.sv
// tb_axis_lane_adder: randomized and directed checks of the lane adder against a packet-level model
module tb_axis_lane_adder;
   localparam int DW = 8, LANES = 4, CNTW = 16, W = 32, MAXV = 255;
   logic clk, rst, m_force, bp_rand, rst_seen;
   logic [DW-1:0] cfg_addend;
   logic [1:0] cfg_mode;
   logic [CNTW-1:0] pkt_count, ovf_count;
   int total, bad, rdy_low;
   logic [W+1:0] exp_q[$];
   logic [W-1:0] o_data[$];
   logic o_user[$];
   int m_pkt, m_ovf, p_add, p_mode;
   logic p_busy, p_sticky, e, u;
   logic [W-1:0] r;
   logic [W:0] mb;
   logic [W-1:0] bp[6];

   axis_lane_adder_if #(.W(W)) s_if ();
   axis_lane_adder_if #(.W(W)) m_if ();

   axis_lane_adder #(.DW(DW), .LANES(LANES), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .s(s_if), .m(m_if),
      .cfg_addend(cfg_addend), .cfg_mode(cfg_mode),
      .pkt_count(pkt_count), .ovf_count(ovf_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst)
      if (!rst) rst_seen <= 1'b0;
      else rst_seen <= 1'b1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
      end
   endtask

   // Packet-level reference: each lane computed with plain integer arithmetic
   function automatic logic [W:0] model_beat(input logic [W-1:0] d, input int a, input int md);
      logic [W-1:0] res = '0;
      logic ev = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         int v = int'(d[i*DW +: DW]);
         int x = v;
         if (md == 0) begin
            x = (v + a) % (MAXV + 1);
            ev |= (v + a) > MAXV;
         end else if (md == 1) begin
            x = (v + a > MAXV) ? MAXV : v + a;
            ev |= (v + a) > MAXV;
         end else if (md == 2) begin
            x = (v < a) ? 0 : v - a;
            ev |= v < a;
         end
         res[i*DW +: DW] = x[DW-1:0];
      end
      return {ev, res};
   endfunction

   // Per-cycle compare against the model, then advance the model by this cycle's handshakes
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         m_pkt = 0; m_ovf = 0; p_busy = 0; p_sticky = 0;
         chk("rst_s_tready", s_if.tready, 0);
         chk("rst_m_tvalid", m_if.tvalid, 0);
         chk("rst_pkt_count", pkt_count, 0);
         chk("rst_ovf_count", ovf_count, 0);
      end else if (!rst_seen) begin
         chk("pre_edge_s_tready", s_if.tready, 0);
         chk("pre_edge_m_tvalid", m_if.tvalid, 0);
      end else begin
         if (!s_if.tready) rdy_low++;
         chk("s_tready", s_if.tready, exp_q.size() < 2);
         chk("m_tvalid", m_if.tvalid, exp_q.size() > 0);
         if (m_if.tvalid && exp_q.size() > 0)
            chk("m_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, exp_q[0]);
         chk("pkt_count", pkt_count, m_pkt[CNTW-1:0]);
         chk("ovf_count", ovf_count, m_ovf[CNTW-1:0]);
         if (m_if.tvalid && m_if.tready && exp_q.size() > 0) begin
            o_data.push_back(m_if.tdata);
            o_user.push_back(m_if.tuser);
            if (exp_q[0][W]) begin
               m_pkt = (m_pkt + 1) % 65536;
               if (exp_q[0][W+1] && m_ovf != 65535) m_ovf++;
            end
            void'(exp_q.pop_front());
         end
         if (s_if.tvalid && s_if.tready) begin
            if (!p_busy) begin
               p_add = int'(cfg_addend);
               p_mode = int'(cfg_mode);
            end
            {e, r} = model_beat(s_if.tdata, p_add, p_mode);
            u = s_if.tlast && (p_sticky || e);
            p_sticky = !s_if.tlast && (p_sticky || e);
            p_busy = !s_if.tlast;
            exp_q.push_back({u, s_if.tlast, r});
         end
      end
   end

   initial begin
      m_if.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_if.tready = bp_rand ? ($urandom_range(0, 3) != 0) : m_force;
      end
   end

   task automatic send(input logic [W-1:0] d, input logic l, input logic [DW-1:0] a, input logic [1:0] md);
      s_if.tdata = d; s_if.tlast = l; cfg_addend = a; cfg_mode = md; s_if.tvalid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (s_if.tready) begin
            @(posedge clk);
            #1;
            s_if.tvalid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 1, 0);
      s_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_if.tvalid) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      chk("drain_timeout", 1, 0);
   endtask

   initial begin
      total = 0; bad = 0; rdy_low = 0;
      rst = 1'b0; m_force = 1'b1; bp_rand = 1'b0;
      s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      cfg_addend = '0; cfg_mode = 2'd0;
      bp = '{32'h01020304, 32'hA0B0C0D0, 32'hFFFFFFFF, 32'h00000000, 32'h5A5AA5A5, 32'h13579BDF};
      mb = model_beat(32'hFFF02001, 16, 0);
      chk("pin_wrap", mb, 33'h1_0F003011);
      mb = model_beat(32'hF001E07F, 32, 1);
      chk("pin_sat_add", mb, 33'h1_FF21FF9F);
      mb = model_beat(32'h01020304, 1, 2);
      chk("pin_sat_sub", mb, 33'h0_00010203);
      mb = model_beat(32'h00010203, 1, 2);
      chk("pin_sat_sub_borrow", mb, 33'h1_00000102);
      mb = model_beat(32'hDEADBEEF, 200, 3);
      chk("pin_bypass", mb, 33'h0_DEADBEEF);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tdata", m_if.tdata, 0);
      chk("rst_m_tlast", m_if.tlast, 0);
      chk("rst_m_tuser", m_if.tuser, 0);
      rst = 1'b1;
      send(32'hFFF02001, 1'b1, 8'h10, 2'd0);
      drain();
      chk("wrap_data", o_data[$], 32'h0F003011);
      chk("wrap_user", o_user[$], 1);
      chk("wrap_pkt", pkt_count, 1);
      send(32'hF001E07F, 1'b1, 8'h20, 2'd1);
      drain();
      chk("sat_add_data", o_data[$], 32'hFF21FF9F);
      chk("sat_add_user", o_user[$], 1);
      chk("sat_add_ovf", ovf_count, 2);
      o_data.delete(); o_user.delete();
      send(32'h01020304, 1'b0, 8'd5, 2'd0);
      send(32'h10101010, 1'b0, 8'd9, 2'd0);
      send(32'h10101010, 1'b1, 8'd9, 2'd0);
      send(32'h01020304, 1'b1, 8'd9, 2'd0);
      drain();
      chk("latch_beat0", o_data[0], 32'h06070809);
      chk("latch_beat2", o_data[2], 32'h15151515);
      chk("latch_next_pkt", o_data[3], 32'h0A0B0C0D);
      o_data.delete(); o_user.delete(); rdy_low = 0;
      fork
         for (int i = 0; i < 6; i++) send(bp[i], i == 5, 8'h77, 2'd3);
         begin
            repeat (3) @(posedge clk);
            m_force = 1'b0;
            repeat (3) @(posedge clk);
            m_force = 1'b1;
         end
      join
      drain();
      for (int i = 0; i < 6; i++) chk("bp_order", o_data[i], bp[i]);
      chk("bp_ready_fell", rdy_low > 0, 1);
      send(32'h01FF8002, 1'b0, 8'd1, 2'd2);
      send(32'h02030405, 1'b0, 8'd1, 2'd2);
      send(32'h10203040, 1'b0, 8'd1, 2'd2);
      send(32'h80808001, 1'b1, 8'd1, 2'd2);
      drain();
      chk("sub_data", o_data[$], 32'h7F7F7F00);
      chk("sub_user", o_user[$], 0);
      chk("sub_ovf", ovf_count, 2);
      chk("sub_pkt", pkt_count, 6);
      m_force = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      s_if.tdata = 32'h11111111; s_if.tlast = 1'b0; cfg_addend = 8'd7; cfg_mode = 2'd0; s_if.tvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_full_ready", s_if.tready, 0);
      chk("mid_full_valid", m_if.tvalid, 1);
      #1 rst = 1'b0;
      #1;
      chk("async_m_tvalid", m_if.tvalid, 0);
      chk("async_pkt", pkt_count, 0);
      s_if.tvalid = 1'b0; m_force = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      send(32'h01010101, 1'b1, 8'd3, 2'd0);
      drain();
      chk("post_rst_data", o_data[$], 32'h04040404);
      chk("post_rst_pkt", pkt_count, 1);
      bp_rand = 1'b1;
      for (int p = 0; p < 200; p++) begin
         int len = $urandom_range(1, 5);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 2) == 0) begin
               @(posedge clk);
               #1;
            end
            send($urandom, b == len - 1, DW'($urandom), 2'($urandom_range(0, 3)));
         end
      end
      bp_rand = 1'b0;
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
